// File: rtl/neuron_row_accum_pkg.sv
// Shared types and constants for the neuron row accumulator.
package neuron_row_accum_pkg;

  // Controller phases: gather partial sums, then emit one result per column.
  typedef enum logic {
    ACCUM = 1'b0,
    FIRE  = 1'b1
  } state_e;

  // Membrane behaviour after a spike.
  localparam int RST_SUB  = 0;  // subtract the threshold
  localparam int RST_ZERO = 1;  // clear to zero

endpackage

// File: rtl/neuron_row_accum_lif_fire.sv
// Leaky-integrate-and-fire decision for one membrane value (no leak term).
// Purely combinational: compares against the threshold and produces the
// value the membrane should hold once the result has been delivered.
module lif_fire #(
  parameter int MEM_W = 8
) (
  input  logic [MEM_W-1:0] vmem,
  input  logic [MEM_W-1:0] thresh,
  input  logic             mode,      // 1 = zero on spike, 0 = subtract
  output logic             spike,
  output logic [MEM_W-1:0] vmem_post
);

  // Threshold compare and post-spike membrane selection.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which is what keeps a combinational block from inferring a latch.
    spike     = (vmem >= thresh);
    vmem_post = vmem;
    if (spike) begin
      vmem_post = mode ? '0 : (vmem - thresh);
    end
  end

endmodule

// File: rtl/neuron_row_accum.sv
// Row of NUM_COLS output neurons. Each timestep collects NUM_PARTIALS
// partial sums per column into a saturating membrane, then walks the columns
// emitting spike/membrane results over a valid/ready stream before accepting
// the next timestep. Membranes persist across timesteps.
module neuron_row_accum
  import neuron_row_accum_pkg::*;
#(
  parameter int  NUM_COLS     = 3,
  parameter int  NUM_PARTIALS = 3,
  parameter int  PSUM_W       = 8,
  parameter int  MEM_W        = 8,
  parameter int  THRESH       = 64,
  parameter int  RESET_MODE   = 0,
  localparam int COL_W        = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int CNT_W        = $clog2(NUM_PARTIALS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COL_W-1:0]  in_col,
  input  logic [PSUM_W-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COL_W-1:0]  out_col,
  output logic              out_spike,
  output logic [MEM_W-1:0]  out_vmem,
  output logic              out_last,
  output logic              ts_done,
  output logic              err
);

  // Adder is one bit wider than the wider operand so overflow is visible.
  localparam int SUM_W = ((MEM_W > PSUM_W) ? MEM_W : PSUM_W) + 1;
  localparam logic [SUM_W-1:0] MEM_MAX = {{(SUM_W - MEM_W){1'b0}}, {MEM_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_PARTIALS);

  state_e           state;
  logic [MEM_W-1:0] vmem  [NUM_COLS];
  logic [CNT_W-1:0] count [NUM_COLS];
  logic [COL_W-1:0] p;

  logic             accept;
  logic             col_ok;
  logic             slot_ok;
  logic             take;
  logic             all_full_next;
  logic [SUM_W-1:0] sum_wide;
  logic [MEM_W-1:0] sum_sat;
  logic             fire_spike;
  logic [MEM_W-1:0] fire_vmem;

  // Decode the offered partial: is it legal, what would the membrane become,
  // and will this acceptance complete the whole row.
  always_comb begin
    accept   = in_valid && in_ready;
    col_ok   = int'(in_col) < NUM_COLS;
    slot_ok  = 1'b0;
    sum_wide = '0;
    if (col_ok) begin
      slot_ok  = count[in_col] < CNT_FULL;
      sum_wide = SUM_W'(vmem[in_col]) + SUM_W'(in_psum);
    end
    sum_sat = (sum_wide > MEM_MAX) ? '1 : sum_wide[MEM_W-1:0];
    take    = accept && col_ok && slot_ok;

    all_full_next = 1'b1;
    for (int c = 0; c < NUM_COLS; c++) begin
      if ((count[c] + CNT_W'(take && (int'(in_col) == c))) != CNT_FULL) begin
        all_full_next = 1'b0;
      end
    end
  end

  // Spike decision for the column currently being emitted.
  lif_fire #(
    .MEM_W (MEM_W)
  ) u_lif_fire (
    .vmem      (vmem[p]),
    .thresh    (MEM_W'(THRESH)),
    .mode      (RESET_MODE == RST_ZERO),
    .spike     (fire_spike),
    .vmem_post (fire_vmem)
  );

  // Result payload comes straight from held state, so it is stable under
  // back-pressure without extra output registers.
  assign out_col   = p;
  assign out_spike = fire_spike;
  assign out_vmem  = fire_vmem;
  assign out_last  = (int'(p) == NUM_COLS - 1);

  // Controller: accumulation, per-column firing and timestep bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      p         <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      ts_done   <= 1'b0;
      err       <= 1'b0;
      // NOTE: the membrane/count arrays are reset explicitly because a reset
      // must also abandon a half-finished timestep; that rules out RAM mapping.
      for (int c = 0; c < NUM_COLS; c++) begin
        vmem[c]  <= '0;
        count[c] <= '0;
      end
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      ts_done <= 1'b0;
      case (state)
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (take) begin
              vmem[in_col]  <= sum_sat;
              count[in_col] <= count[in_col] + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
          if (all_full_next) begin
            state     <= FIRE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            p         <= '0;
          end
        end
        FIRE: begin
          if (out_valid && out_ready) begin
            vmem[p]  <= fire_vmem;
            count[p] <= '0;
            if (out_last) begin
              state     <= ACCUM;
              p         <= '0;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              ts_done   <= 1'b1;
            end else begin
              p <= p + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
